// File: rtl/bringup_pkg.sv
// Shared definitions for the bring-up sequencer: FSM state codes (also shown on
// the seven-segment display) and counter sizing helpers.
package bringup_pkg;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_STARTUP    = 4'd1,
      S_INIT_START = 4'd2,
      S_INIT_WAIT  = 4'd3,
      S_RD_START   = 4'd4,
      S_RD_WAIT    = 4'd5,
      S_FAIL       = 4'd6
   } state_t;

   // us_cnt must hold the larger of the startup delay and the timeout
   function automatic int us_cnt_w(input int delay_us, input int timeout_us);
      int m;
      m = (delay_us > timeout_us) ? delay_us : timeout_us;
      return $clog2(m + 1);
   endfunction

   // a 1 MHz clock still needs a one-bit prescaler register
   function automatic int pre_w(input int freq_mhz);
      return (freq_mhz > 1) ? $clog2(freq_mhz) : 1;
   endfunction

endpackage

// File: rtl/us_timer.sv
// Microsecond timebase: prescaler divides clk down to a 1 us tick, us count
// advances on every tick. A synchronous clear restarts both.
module us_timer #(
   parameter int CLK_FREQ_MHZ = 125,
   parameter int PRE_W        = 7,
   parameter int CNT_W        = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_MHZ - 1);

   logic [PRE_W-1:0] presc;

   assign tick = (presc == PRE_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         count <= '0;
      end else if (clear) begin
         presc <= '0;
         count <= '0;
      end else if (tick) begin
         presc <= '0;
         count <= count + CNT_W'(1);
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

endmodule

// File: rtl/bringup_seq.sv
// Power-up sequencer: startup hold-off, ordered per-device init with timeout and
// retry, register-read servicing, and re-init on a hot-plug/interrupt edge.
module bringup_seq
   import bringup_pkg::*;
#(
   parameter int NUM_DEV       = 2,
   parameter int CLK_FREQ_MHZ  = 125,
   parameter int INIT_DELAY_US = 250000,
   parameter int TIMEOUT_US    = 100000,
   parameter int MAX_RETRY     = 3
) (
   input  logic               clk,
   input  logic               reset,
   output logic [NUM_DEV-1:0] init_start,
   input  logic [NUM_DEV-1:0] init_done,
   input  logic               rd_req,
   output logic               rd_start,
   input  logic               rd_done,
   output logic               rd_err,
   input  logic               reinit_req,
   output logic               ready,
   output logic               fail,
   output logic [2:0]         fail_dev,
   output logic [3:0]         state_out
);

   localparam int               CNT_W      = us_cnt_w(INIT_DELAY_US, TIMEOUT_US);
   localparam int               PRE_W      = pre_w(CLK_FREQ_MHZ);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(INIT_DELAY_US - 1);
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_US - 1);
   localparam logic [2:0]       LAST_DEV   = 3'(NUM_DEV - 1);
   localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

   state_t               state, state_nxt;
   logic [2:0]           dev_idx, dev_idx_nxt, fail_dev_nxt;
   logic [3:0]           retry, retry_nxt;
   logic                 pending, pending_nxt;
   logic                 ready_nxt, fail_nxt, rd_err_nxt;
   logic [NUM_DEV-1:0]   init_start_nxt;
   logic [2:0]           sync;
   logic                 reinit, tick, tmo, done_sel;
   logic [CNT_W-1:0]     us_cnt;

   // sync[1:0] is the two-flop synchroniser, sync[2] the edge-detect history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[1:0], reinit_req};
   end

   assign reinit    = sync[1] & ~sync[2];
   assign tmo       = tick && (us_cnt == TMO_LAST);
   assign state_out = state;

   us_timer #(
      .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
      .PRE_W        (PRE_W),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state_nxt != state),
      .tick  (tick),
      .count (us_cnt)
   );

   always_comb begin
      done_sel       = 1'b0;
      init_start_nxt = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (dev_idx == 3'(i)) done_sel = init_done[i];
         init_start_nxt[i] = (state_nxt == S_INIT_START) && (dev_idx_nxt == 3'(i));
      end
   end

   always_comb begin
      state_nxt    = state;
      dev_idx_nxt  = dev_idx;
      retry_nxt    = retry;
      ready_nxt    = ready;
      fail_nxt     = fail;
      fail_dev_nxt = fail_dev;
      rd_err_nxt   = 1'b0;
      // an edge seen while busy is remembered and honoured on return to idle
      pending_nxt  = pending | (reinit & (state != S_IDLE) & (state != S_FAIL));
      case (state)
         S_STARTUP: begin
            if (tick && us_cnt == DELAY_LAST) begin
               state_nxt   = S_INIT_START;
               dev_idx_nxt = '0;
               retry_nxt   = '0;
            end
         end
         S_INIT_START: state_nxt = S_INIT_WAIT;
         S_INIT_WAIT: begin
            if (done_sel) begin
               if (dev_idx == LAST_DEV) begin
                  state_nxt = S_IDLE;
                  ready_nxt = 1'b1;
               end else begin
                  dev_idx_nxt = dev_idx + 3'd1;
                  retry_nxt   = '0;
                  state_nxt   = S_INIT_START;
               end
            end else if (tmo) begin
               if (retry < RETRY_MAX) begin
                  retry_nxt = retry + 4'd1;
                  state_nxt = S_INIT_START;
               end else begin
                  state_nxt    = S_FAIL;
                  fail_nxt     = 1'b1;
                  fail_dev_nxt = dev_idx;
               end
            end
         end
         S_IDLE: begin
            if (reinit || pending) begin
               ready_nxt   = 1'b0;
               pending_nxt = 1'b0;
               dev_idx_nxt = '0;
               retry_nxt   = '0;
               state_nxt   = S_INIT_START;
            end else if (rd_req) begin
               state_nxt = S_RD_START;
            end
         end
         S_RD_START: state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (rd_done) begin
               state_nxt = S_IDLE;
            end else if (tmo) begin
               rd_err_nxt = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         S_FAIL: begin
            if (reinit) begin
               fail_nxt    = 1'b0;
               dev_idx_nxt = '0;
               retry_nxt   = '0;
               state_nxt   = S_INIT_START;
            end
         end
         default: state_nxt = S_STARTUP;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_STARTUP;
         dev_idx    <= '0;
         retry      <= '0;
         pending    <= 1'b0;
         ready      <= 1'b0;
         fail       <= 1'b0;
         fail_dev   <= '0;
         rd_err     <= 1'b0;
         rd_start   <= 1'b0;
         init_start <= '0;
      end else begin
         state      <= state_nxt;
         dev_idx    <= dev_idx_nxt;
         retry      <= retry_nxt;
         pending    <= pending_nxt;
         ready      <= ready_nxt;
         fail       <= fail_nxt;
         fail_dev   <= fail_dev_nxt;
         rd_err     <= rd_err_nxt;
         rd_start   <= (state_nxt == S_RD_START);
         init_start <= init_start_nxt;
      end
   end

endmodule

// File: tb/tb_bringup_seq.sv
// Bench for bringup_seq: directed scenarios with device/read responders, a
// phase/elapsed-time reference model checked every cycle, plus literal pins.
module tb_bringup_seq;

   localparam int N    = 2;
   localparam int CLKF = 2;
   localparam int DLY  = 20;
   localparam int TMO  = 10;
   localparam int MR   = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] init_start, init_done;
   logic         rd_req = 1'b0, rd_start, rd_done, rd_err;
   logic         reinit_req = 1'b0, ready, fail;
   logic [2:0]   fail_dev;
   logic [3:0]   state_out;

   int n_cmp = 0, n_bad = 0, cyc = 0;
   bit chk_on = 1'b0;

   bringup_seq #(
      .NUM_DEV(N), .CLK_FREQ_MHZ(CLKF), .INIT_DELAY_US(DLY),
      .TIMEOUT_US(TMO), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .reset(rst_n), .init_start(init_start), .init_done(init_done),
      .rd_req(rd_req), .rd_start(rd_start), .rd_done(rd_done), .rd_err(rd_err),
      .reinit_req(reinit_req), .ready(ready), .fail(fail), .fail_dev(fail_dev),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase code plus cycles elapsed in that phase; deadlines are plain products.
   int           m_phase = 1, m_el = 0, m_dev = 0, m_try = 0, m_fdev = 0, m_nxt = 1;
   bit           m_pend = 0, m_ready = 0, m_fail = 0, m_pulse = 0;
   bit [2:0]     rq_hist = '0;
   logic [N-1:0] exp_init_start = '0;
   bit           exp_rd_start = 0, exp_rd_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 1; m_el = 0; m_dev = 0; m_try = 0; m_fdev = 0;
         m_pend = 0; m_ready = 0; m_fail = 0; rq_hist = '0;
         exp_init_start = '0; exp_rd_start = 0; exp_rd_err = 0;
      end else begin
         // an interrupt edge takes effect two sampling edges after it is seen
         m_pulse = rq_hist[1] && !rq_hist[2];
         rq_hist = {rq_hist[1:0], reinit_req};
         m_nxt = m_phase;
         exp_rd_err = 0;
         if (m_pulse && m_phase >= 1 && m_phase <= 5) m_pend = 1;
         case (m_phase)
            1: if (m_el == DLY*CLKF - 1) begin m_nxt = 2; m_dev = 0; m_try = 0; end
            2: m_nxt = 3;
            3: begin
               if (init_done[m_dev]) begin
                  if (m_dev == N-1) begin m_nxt = 0; m_ready = 1; end
                  else begin m_dev++; m_try = 0; m_nxt = 2; end
               end else if (m_el == TMO*CLKF - 1) begin
                  if (m_try < MR) begin m_try++; m_nxt = 2; end
                  else begin m_nxt = 6; m_fail = 1; m_fdev = m_dev; end
               end
            end
            0: begin
               if (m_pulse || m_pend) begin
                  m_ready = 0; m_pend = 0; m_dev = 0; m_try = 0; m_nxt = 2;
               end else if (rd_req) m_nxt = 4;
            end
            4: m_nxt = 5;
            5: begin
               if (rd_done) m_nxt = 0;
               else if (m_el == TMO*CLKF - 1) begin exp_rd_err = 1; m_nxt = 0; end
            end
            6: if (m_pulse) begin m_fail = 0; m_dev = 0; m_try = 0; m_nxt = 2; end
            default: m_nxt = 1;
         endcase
         m_el = (m_nxt != m_phase) ? 0 : m_el + 1;
         m_phase = m_nxt;
         exp_init_start = '0;
         if (m_nxt == 2) exp_init_start[m_dev] = 1'b1;
         exp_rd_start = (m_nxt == 4);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("init_start", 32'(init_start), 32'(exp_init_start));
         chk("rd_start",   32'(rd_start),   32'(exp_rd_start));
         chk("rd_err",     32'(rd_err),     32'(exp_rd_err));
         chk("ready",      32'(ready),      32'(m_ready));
         chk("fail",       32'(fail),       32'(m_fail));
         chk("fail_dev",   32'(fail_dev),   32'(m_fdev));
         chk("state_out",  32'(state_out),  32'(m_phase));
      end
   end

   // ---------------- responders ----------------
   int dcnt [N];
   int dly  [N];
   bit [N-1:0] dev_en = '1;
   int rd_cnt = 0;
   bit rd_en = 1'b1;

   initial begin
      init_done = '0;
      for (int i = 0; i < N; i++) begin dcnt[i] = 0; dly[i] = 5; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            init_done[i] = 1'b0;
            if (!rst_n) dcnt[i] = 0;
            else begin
               if (dcnt[i] > 0) begin
                  dcnt[i]--;
                  if (dcnt[i] == 0) init_done[i] = 1'b1;
               end
               if (init_start[i] && dev_en[i]) dcnt[i] = dly[i];
            end
         end
      end
   end

   initial begin
      rd_done = 1'b0;
      forever begin
         @(negedge clk);
         rd_done = 1'b0;
         if (!rst_n) rd_cnt = 0;
         else begin
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) rd_done = 1'b1;
            end
            if (rd_start && rd_en) rd_cnt = 7;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic at_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic check_reset();
      chk("rst_init_start", 32'(init_start), 32'd0);
      chk("rst_rd_start",   32'(rd_start),   32'd0);
      chk("rst_rd_err",     32'(rd_err),     32'd0);
      chk("rst_ready",      32'(ready),      32'd0);
      chk("rst_fail",       32'(fail),       32'd0);
      chk("rst_fail_dev",   32'(fail_dev),   32'd0);
      chk("rst_state",      32'(state_out),  32'd1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 chk_on = 1'b1;
      repeat (3) @(negedge clk);
      check_reset();
      rst_n = 1'b1;

      // normal bring-up: both devices answer 5 cycles after start
      at_cyc(39); chk("startup_hold", 32'(state_out), 32'd1);
      at_cyc(40); chk("first_start0", 32'(init_start), 32'b01);
      at_cyc(46); chk("first_start1", 32'(init_start), 32'b10);
      at_cyc(51); chk("ready_pre", 32'(ready), 32'd0);
      at_cyc(52); chk("ready_up", 32'(ready), 32'd1);
      chk("idle_code", 32'(state_out), 32'd0);

      // read answered 7 cycles after rd_start
      at_cyc(60); rd_req = 1'b1;
      at_cyc(61); chk("rd_start_lit", 32'(rd_start), 32'd1); rd_req = 1'b0;
      at_cyc(68); chk("rd_wait_code", 32'(state_out), 32'd5);
      at_cyc(69); chk("rd_back_idle", 32'(state_out), 32'd0);
      chk("rd_ready_kept", 32'(ready), 32'd1);

      // read never answered: timeout pulse
      at_cyc(80); rd_en = 1'b0; rd_req = 1'b1;
      at_cyc(81); rd_req = 1'b0;
      at_cyc(101); chk("rd_err_pre", 32'(rd_err), 32'd0);
      at_cyc(102); chk("rd_err_lit", 32'(rd_err), 32'd1);
      at_cyc(103); chk("rd_err_once", 32'(rd_err), 32'd0);

      // interrupt during a read: read completes, then re-init
      at_cyc(120); rd_en = 1'b1; rd_req = 1'b1;
      at_cyc(121); rd_req = 1'b0;
      at_cyc(123); reinit_req = 1'b1;
      at_cyc(129); chk("pend_idle", 32'(state_out), 32'd0);
      chk("pend_ready_kept", 32'(ready), 32'd1);
      at_cyc(130); chk("pend_start0", 32'(init_start), 32'b01);
      chk("pend_ready_drop", 32'(ready), 32'd0);
      at_cyc(142); chk("pend_ready_up", 32'(ready), 32'd1);
      at_cyc(145); reinit_req = 1'b0;

      // device 0 done exactly on its timeout cycle: done wins, no retry
      at_cyc(160); dly[0] = 20; reinit_req = 1'b1;
      at_cyc(163); chk("tie_start0", 32'(init_start), 32'b01);
      at_cyc(170); reinit_req = 1'b0;
      at_cyc(184); chk("tie_start1", 32'(init_start), 32'b10);
      dly[0] = 5;
      at_cyc(190); chk("tie_ready", 32'(ready), 32'd1);

      // fresh reset with device 1 dead: retry, then fail
      at_cyc(200); @(negedge clk);
      #2 rst_n = 1'b0; dev_en[1] = 1'b0;
      #1 check_reset();
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      at_cyc(46); chk("f_start1a", 32'(init_start), 32'b10);
      at_cyc(67); chk("f_start1b", 32'(init_start), 32'b10);
      at_cyc(87); chk("f_pre", 32'(fail), 32'd0);
      at_cyc(88); chk("f_fail", 32'(fail), 32'd1);
      chk("f_dev", 32'(fail_dev), 32'd1);
      chk("f_code", 32'(state_out), 32'd6);

      // recover with an interrupt, then reset in the middle of init
      at_cyc(95); dev_en[1] = 1'b1; reinit_req = 1'b1;
      at_cyc(97); chk("f_hold", 32'(fail), 32'd1);
      at_cyc(98); chk("f_clear", 32'(fail), 32'd0);
      chk("f_restart0", 32'(init_start), 32'b01);
      at_cyc(101); chk("w_code", 32'(state_out), 32'd3);
      #2 rst_n = 1'b0; reinit_req = 1'b0;
      #1 check_reset();
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      at_cyc(39); chk("r_hold", 32'(init_start), 32'd0);
      at_cyc(40); chk("r_start0", 32'(init_start), 32'b01);
      at_cyc(52); chk("r_ready", 32'(ready), 32'd1);
      at_cyc(56);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, expected finish before t=200000");
      $fatal(1);
   end

endmodule
